// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb
//   Writeback arbiter and busy-register scoreboard for the register file's
//   single rd write port. NREQ producers (0=ALU, 1=LSU, 2=FPU) compete with a
//   valid/ready handshake. At most one result is accepted per cycle and is
//   registered toward the register file. A 32-bit busy vector tracks
//   destinations whose results are still outstanding, so issue can stall on
//   RAW hazards.
//
//   Build option: define WB_ARB_RR_EN for round-robin arbitration, which
//   starts searching at last_ptr+1. Leave it undefined for fixed priority,
//   where the lowest index wins and there is no last_ptr state.
//
// Ports
//   clk_i, rst_i    clock; asynchronous active-high reset
//   req_valid_i     per-requester result valid
//   req_rd_i        per-requester destination, 5 bits each, packed
//   req_data_i      per-requester result, XLEN bits each, packed
//   req_ready_o     one-hot grant (combinational)
//   issue_valid_i   instruction issued this cycle that writes issue_rd_i
//   issue_rd_i      its destination register
//   sb_busy_o       registered pending-writeback flags; bit 0 is always 0
//   rd_addr_o       registered register-file write address
//   rd_data_o       registered register-file write data
//   rd_wren_o       registered register-file write enable
//   grant_id_o      requester accepted in the previous transfer (debug)
module regfile_wb_arb #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*5-1:0]        req_rd_i,
    input  logic [NREQ*XLEN-1:0]     req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic                     issue_valid_i,
    input  logic [4:0]               issue_rd_i,
    output logic [31:0]              sb_busy_o,
    output logic [4:0]               rd_addr_o,
    output logic [XLEN-1:0]          rd_data_o,
    output logic                     rd_wren_o,
    output logic [$clog2(NREQ)-1:0]  grant_id_o
);
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0] gnt;
    logic            xfer;
    logic [GW-1:0]   win_idx;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;

    logic [4:0]      rd_addr_q;
    logic [XLEN-1:0] rd_data_q;
    logic            rd_wren_q;
    logic [GW-1:0]   grant_id_q;
    logic [31:0]     busy_q, busy_d;

`ifdef WB_ARB_RR_EN
    // Pointer to the most recent winner. Searching starts just past it.
    logic [GW-1:0] last_ptr_q;

    always_comb begin
        automatic int  idx;
        automatic logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid_i[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // The pointer holds when no request is valid. The reset value NREQ-1
    // makes requester 0 win first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     last_ptr_q <= GW'(NREQ - 1);
        else if (xfer) last_ptr_q <= win_idx;
    end
`else
    // Fixed priority: the lowest index wins.
    always_comb begin
        automatic logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid_i[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

    assign req_ready_o = gnt;
    assign xfer        = |gnt;

    // Select the winning requester's rd and data from the one-hot grant.
    always_comb begin
        win_idx  = '0;
        win_rd   = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_idx  = GW'(i);
                win_rd   = req_rd_i[5*i +: 5];
                win_data = req_data_i[XLEN*i +: XLEN];
            end
        end
    end

    // The clear is applied first and the set second, so a same-cycle issue
    // to the same rd wins: a newer producer is in flight. x0 is never tracked.
    always_comb begin
        busy_d = busy_q;
        if (xfer && win_rd != 5'd0)               busy_d[win_rd]     = 1'b0;
        if (issue_valid_i && issue_rd_i != 5'd0)  busy_d[issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // x0 results still consume the grant, but they never raise the write enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_wren_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            grant_id_q <= '0;
            busy_q     <= '0;
        end else begin
            rd_wren_q <= xfer && (win_rd != 5'd0);
            if (xfer) begin
                rd_addr_q  <= win_rd;
                rd_data_q  <= win_data;
                grant_id_q <= win_idx;
            end
            busy_q <= busy_d;
        end
    end

    assign rd_wren_o  = rd_wren_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_data_o  = rd_data_q;
    assign grant_id_o = grant_id_q;
    assign sb_busy_o  = busy_q;
endmodule

// File: tb/tb_regfile_wb_arb.sv
module tb_regfile_wb_arb;
    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [NREQ-1:0]         req_valid_i;
    logic [NREQ*5-1:0]       req_rd_i;
    logic [NREQ*XLEN-1:0]    req_data_i;
    logic [NREQ-1:0]         req_ready_o;
    logic                    issue_valid_i;
    logic [4:0]              issue_rd_i;
    logic [31:0]             sb_busy_o;
    logic [4:0]              rd_addr_o;
    logic [XLEN-1:0]         rd_data_o;
    logic                    rd_wren_o;
    logic [$clog2(NREQ)-1:0] grant_id_o;

    regfile_wb_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_rd_i(req_rd_i), .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .sb_busy_o(sb_busy_o),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .rd_wren_o(rd_wren_o),
        .grant_id_o(grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [NREQ-1:0]      vld;
        logic [NREQ*5-1:0]    rd;
        logic [NREQ*XLEN-1:0] dat;
        logic                 iv;
        logic [4:0]           ird;
        logic [NREQ-1:0]      rdy;
    } vec_t;

    typedef struct {
        logic        wren;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  gid;
        logic [31:0] busy;
    } wr_t;

    wr_t exp_q[$];
    vec_t tbl[12];

    int n_vec = 0;
    int n_err = 0;

    // Reference state for the registered outputs.
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_gid;
    logic [31:0] m_busy;

    function automatic vec_t mk(logic [2:0] vld, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic iv, logic [4:0] ird, logic [2:0] rdy);
        vec_t v;
        v.vld = vld; v.rd = {r2, r1, r0}; v.dat = {d2, d1, d0};
        v.iv = iv; v.ird = ird; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called #1 after a rising edge. It drives one vector, checks the
    // combinational grant, updates the model, crosses the next edge and
    // compares the registered outputs against the queued expectation.
    task automatic apply(input vec_t v);
        wr_t e;
        req_valid_i = v.vld; req_rd_i = v.rd; req_data_i = v.dat;
        issue_valid_i = v.iv; issue_rd_i = v.ird;
        #1;
        chk("ready", 64'(req_ready_o), 64'(v.rdy));
        e.wren = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (v.rdy[i]) begin
                m_addr = v.rd[5*i +: 5];
                m_data = v.dat[XLEN*i +: XLEN];
                m_gid  = 2'(i);
                e.wren = (m_addr != 5'd0);
                if (m_addr != 5'd0) m_busy[m_addr] = 1'b0;
            end
        end
        if (v.iv && v.ird != 5'd0) m_busy[v.ird] = 1'b1;
        e.addr = m_addr; e.data = m_data; e.gid = m_gid; e.busy = m_busy;
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        e = exp_q.pop_front();
        chk("rd_wren", 64'(rd_wren_o), 64'(e.wren));
        chk("rd_addr", 64'(rd_addr_o), 64'(e.addr));
        chk("rd_data", 64'(rd_data_o), 64'(e.data));
        chk("grant_id", 64'(grant_id_o), 64'(e.gid));
        chk("sb_busy", 64'(sb_busy_o), 64'(e.busy));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_wren"}, 64'(rd_wren_o), 64'd0);
        chk({tag, "_addr"}, 64'(rd_addr_o), 64'd0);
        chk({tag, "_data"}, 64'(rd_data_o), 64'd0);
        chk({tag, "_gid"},  64'(grant_id_o), 64'd0);
        chk({tag, "_busy"}, 64'(sb_busy_o), 64'd0);
    endtask

    initial begin
        // Stimulus table
        tbl[0]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        tbl[1]  = mk(3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 3'b010);   // single write
        tbl[2]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 3'b000);               // issue rd=7
        tbl[3]  = mk(3'b001, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 3'b001);        // x0 write
        tbl[4]  = mk(3'b100, 0, 0, 7, 0, 0, 32'h77, 1, 7, 3'b100);          // wb 7 + issue 7
        tbl[5]  = mk(3'b100, 0, 0, 7, 0, 0, 32'h78, 0, 0, 3'b100);          // wb 7 alone
`ifdef WB_ARB_RR_EN
        tbl[6]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC, 1, 1, 3'b001);
        tbl[7]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC, 1, 3, 3'b010);
        tbl[8]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC, 0, 0, 3'b100);
        tbl[9]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC, 0, 0, 3'b001);
`else
        tbl[6]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC, 1, 1, 3'b001);
        tbl[7]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC, 1, 3, 3'b001);
        tbl[8]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC, 0, 0, 3'b001);
        tbl[9]  = mk(3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC, 0, 0, 3'b001);
`endif
        tbl[10] = mk(3'b110, 0, 9, 4, 0, 32'h5A5A, 32'h4444, 1, 9, 3'b010);
        tbl[11] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);

        // Reset state
        rst_i = 1'b1;
        req_valid_i = '0; req_rd_i = '0; req_data_i = '0;
        issue_valid_i = 1'b0; issue_rd_i = '0;
        m_addr = '0; m_data = '0; m_gid = '0; m_busy = '0;
        #2;
        chk_reset_outs("rst");
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // Reset with a pending write: handshake at edge N, reset before N+1.
        req_valid_i = 3'b010; req_rd_i = {5'd0, 5'd12, 5'd0}; req_data_i = {32'd0, 32'hCAFEF00D, 32'd0};
        issue_valid_i = 1'b1; issue_rd_i = 5'd10;
        #1;
        chk("pend_ready", 64'(req_ready_o), 64'b010);
        @(posedge clk_i); #1;
        chk("pend_wren", 64'(rd_wren_o), 64'd1);
        chk("pend_busy10", 64'(sb_busy_o[10]), 64'd1);
        req_valid_i = '0; issue_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk_reset_outs("midrst");
        @(posedge clk_i); #1;
        chk("midrst_edge_wren", 64'(rd_wren_o), 64'd0);
        rst_i = 1'b0;
        m_addr = '0; m_data = '0; m_gid = '0; m_busy = '0;

        // After reset requester 0 wins first in either build.
        apply(mk(3'b111, 13, 14, 15, 32'h11, 32'h22, 32'h33, 0, 0, 3'b001));
        apply(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
